// File: rtl/count_sequencer_if.sv
// count_sequencer_if: control, status and counter-feedback bundle between the run controller and its environment
interface count_sequencer_if #(
  parameter int W = 32,
  parameter int RELOAD_W = 8
);
  logic                start;
  logic                abort;
  logic                pause;
  logic                dir;
  logic                auto_rld;
  logic [W-1:0]        preset;
  logic [W-1:0]        limit;
  logic [W-1:0]        cnt;
  logic                cnt_en;
  logic                s;
  logic                Load;
  logic [W-1:0]        PData;
  logic                busy;
  logic                Rc;
  logic                done;
  logic [RELOAD_W-1:0] rld_cnt;
  modport slave (
    input  start, abort, pause, dir, auto_rld, preset, limit, cnt,
    output cnt_en, s, Load, PData, busy, Rc, done, rld_cnt
  );
  modport master (
    output start, abort, pause, dir, auto_rld, preset, limit, cnt,
    input  cnt_en, s, Load, PData, busy, Rc, done, rld_cnt
  );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: loads a preset into an external up/down counter, runs it to a limit, with reload, pause and abort
module count_sequencer #(
  parameter int W = 32,
  parameter int RELOAD_W = 8
) (
  input logic clk,
  input logic rst,
  count_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d, auto_q, auto_d;
  logic [W-1:0] preset_q, preset_d, limit_q, limit_d;
  logic [RELOAD_W-1:0] rld_q, rld_d;
  logic accept, term;
  // state register and run parameters latched at an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      auto_q   <= 1'b0;
      preset_q <= '0;
      limit_q  <= '0;
      rld_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      auto_q   <= auto_d;
      preset_q <= preset_d;
      limit_q  <= limit_d;
      rld_q    <= rld_d;
    end
  end
  // next state, parameter latching and combinational counter control
  always_comb begin
    accept   = (state_q == IDLE || state_q == DONE) && bus.start && !bus.abort;
    term     = state_q == RUN && bus.cnt == limit_q;
    state_d  = state_q;
    dir_d    = accept ? bus.dir : dir_q;
    auto_d   = accept ? bus.auto_rld : auto_q;
    preset_d = accept ? bus.preset : preset_q;
    limit_d  = accept ? bus.limit : limit_q;
    rld_d    = accept ? '0 : rld_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? LOAD : IDLE;
      LOAD:       state_d = RUN;
      RUN:        state_d = term ? (auto_q ? LOAD : DONE) : (bus.pause ? HOLD : RUN);
      HOLD:       state_d = bus.pause ? HOLD : RUN;
      default:    state_d = IDLE;
    endcase
    if (term && auto_q && !bus.abort && rld_q != '1) rld_d = rld_q + 1'b1;
    if (bus.abort) state_d = IDLE;
    bus.cnt_en  = state_q == RUN && bus.cnt != limit_q && !bus.pause && !bus.abort;
    bus.Load    = state_q == LOAD && !bus.abort;
    bus.Rc      = term && !bus.abort;
    bus.done    = state_q == DONE;
    bus.busy    = state_q == LOAD || state_q == RUN || state_q == HOLD;
    bus.s       = dir_q;
    bus.PData   = preset_q;
    bus.rld_cnt = rld_q;
  end
endmodule
